// File: rtl/velocity_cell_pingpong.sv
// velocity_cell_pingpong: double-buffered per-cell velocity store ({vz, vy, vx}).
//   One bank serves reads to the force/motion pipeline while the other collects
//   appended updates. A handshaked swap (IDLE -> DRAIN -> SWAP) exchanges the two banks.
// Read latency: 1 cycle, or 2 cycles when VELOCITY_RD_OUT_REG_EN is defined. One read per cycle.
// Backpressure: rd_ready=0 in DRAIN/SWAP. wr_ready=0 in SWAP. Appends to a full bank are dropped (overflow).
// Optional macro: VELOCITY_RD_OUT_REG_EN adds an output register stage on rd_data/rd_valid/rd_oob.
// Ports:
//   clk, rst_n                          clock and async active-low reset
//   rd_en/rd_addr/rd_ready              read request into read bank (bank_sel)
//   rd_valid/rd_data/rd_oob/rd_count    read response and read-bank particle count
//   wr_en/wr_data/wr_ready              append into write bank (~bank_sel)
//   wr_count/overflow                   write-bank particle count and sticky drop flag
//   swap_req/swap_done/bank_sel         bank swap handshake and current read bank
module velocity_cell_pingpong #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_oob,
  output logic [ADDR_WIDTH:0]   rd_count,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow,
  input  logic                  swap_req,
  output logic                  swap_done,
  output logic                  bank_sel
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_SWAP} state_t;

  // Reads are blocked for the whole of DRAIN, so a fixed DRAIN length equal to
  // the read pipeline depth is exactly what it takes to empty the pipeline.
`ifdef VELOCITY_RD_OUT_REG_EN
  localparam int LP_DRAIN_CYC = 2;
`else
  localparam int LP_DRAIN_CYC = 1;
`endif
  localparam logic [ADDR_WIDTH:0] LP_FULL = (ADDR_WIDTH+1)'(PARTICLE_NUM);

  logic [DATA_WIDTH-1:0] r_mem_a [0:PARTICLE_NUM-1];
  logic [DATA_WIDTH-1:0] r_mem_b [0:PARTICLE_NUM-1];

  state_t                r_state, w_state_nxt;
  logic                  r_bank_sel;
  logic [ADDR_WIDTH:0]   r_rd_count, r_wr_count;
  logic                  r_overflow, r_swap_done;
  logic                  r_drain_cnt;

  logic                  w_rd_ready, w_wr_ready;
  logic                  w_rd_acc, w_wr_acc, w_rd_oob_req, w_full, w_drain_last;
  logic [DATA_WIDTH-1:0] w_mem_rd, w_rd_word;

  // First read stage (the only stage when the output register is disabled)
  logic                  r_s1_vld, r_s1_oob;
  logic [DATA_WIDTH-1:0] r_s1_data;

  assign w_drain_last = (r_drain_cnt == 1'(LP_DRAIN_CYC - 1));
  assign w_rd_acc     = rd_en & w_rd_ready;
  assign w_wr_acc     = wr_en & w_wr_ready;
  assign w_rd_oob_req = ({1'b0, rd_addr} >= r_rd_count);
  assign w_full       = (r_wr_count == LP_FULL);
  assign w_mem_rd     = r_bank_sel ? r_mem_b[rd_addr] : r_mem_a[rd_addr];
  assign w_rd_word    = w_rd_oob_req ? '0 : w_mem_rd;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and port readiness
  always_comb begin
    w_state_nxt = r_state;
    w_rd_ready  = 1'b0;
    w_wr_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_rd_ready = 1'b1;
        w_wr_ready = 1'b1;
        if (swap_req) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_wr_ready = 1'b1;
        if (w_drain_last) w_state_nxt = ST_SWAP;
      end
      ST_SWAP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Control registers: bank roles, counts, overflow, swap pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_sel  <= 1'b0;
      r_rd_count  <= '0;
      r_wr_count  <= '0;
      r_overflow  <= 1'b0;
      r_swap_done <= 1'b0;
      r_drain_cnt <= 1'b0;
    end else begin
      r_swap_done <= (r_state == ST_SWAP);
      r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 1'b1 : 1'b0;
      if (r_state == ST_SWAP) begin
        r_bank_sel <= ~r_bank_sel;
        r_rd_count <= r_wr_count;
        r_wr_count <= '0;
        r_overflow <= 1'b0;
      end else if (w_wr_acc) begin
        if (w_full) r_overflow <= 1'b1;
        else        r_wr_count <= r_wr_count + 1'b1;
      end
    end
  end

  // Storage: write bank is the one not selected for reads; contents not reset
  always_ff @(posedge clk) begin
    if (w_wr_acc && !w_full) begin
      if (r_bank_sel) r_mem_a[r_wr_count[ADDR_WIDTH-1:0]] <= wr_data;
      else            r_mem_b[r_wr_count[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // Read stage 1: data register holds when no read is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_oob  <= 1'b0;
      r_s1_data <= '0;
    end else begin
      r_s1_vld <= w_rd_acc;
      r_s1_oob <= w_rd_acc & w_rd_oob_req;
      if (w_rd_acc) r_s1_data <= w_rd_word;
    end
  end

`ifdef VELOCITY_RD_OUT_REG_EN
  logic                  r_s2_vld, r_s2_oob;
  logic [DATA_WIDTH-1:0] r_s2_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld  <= 1'b0;
      r_s2_oob  <= 1'b0;
      r_s2_data <= '0;
    end else begin
      r_s2_vld <= r_s1_vld;
      r_s2_oob <= r_s1_oob;
      if (r_s1_vld) r_s2_data <= r_s1_data;
    end
  end

  assign rd_valid = r_s2_vld;
  assign rd_oob   = r_s2_oob;
  assign rd_data  = r_s2_data;
`else
  assign rd_valid = r_s1_vld;
  assign rd_oob   = r_s1_oob;
  assign rd_data  = r_s1_data;
`endif

  assign rd_ready  = w_rd_ready;
  assign wr_ready  = w_wr_ready;
  assign rd_count  = r_rd_count;
  assign wr_count  = r_wr_count;
  assign overflow  = r_overflow;
  assign swap_done = r_swap_done;
  assign bank_sel  = r_bank_sel;

endmodule

// File: tb/tb_velocity_cell_pingpong.sv
// tb_velocity_cell_pingpong: directed checks of the ping-pong velocity store.
// Latency: follows the DUT build (1 or 2 cycle reads).
// Backpressure: exercises refused reads during DRAIN/SWAP and dropped appends when full.
module tb_velocity_cell_pingpong;
  localparam int DW = 96;
  localparam int PN = 220;
  localparam int AW = 8;
`ifdef VELOCITY_RD_OUT_REG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif
  localparam int DRAIN_CYC = RD_LAT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ready, rd_valid, rd_oob;
  logic [DW-1:0] rd_data;
  logic [AW:0]   rd_count, wr_count;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, overflow;
  logic          swap_req = 1'b0;
  logic          swap_done, bank_sel;

  int n_checks = 0;
  int n_errors = 0;

  velocity_cell_pingpong #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_oob(rd_oob), .rd_count(rd_count),
    .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready), .wr_count(wr_count),
    .overflow(overflow), .swap_req(swap_req), .swap_done(swap_done), .bank_sel(bank_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; leaves time just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one read and check the response after the read latency
  task automatic read_chk(input string tag, input logic [AW-1:0] addr,
                          input logic [DW-1:0] exp_data, input logic exp_oob);
    rd_en = 1'b1;
    rd_addr = addr;
    tick();
    rd_en = 1'b0;
    repeat (RD_LAT - 1) tick();
    chk({tag, "_vld"}, 128'(rd_valid), 128'(1'b1));
    chk({tag, "_oob"}, 128'(rd_oob), 128'(exp_oob));
    chk({tag, "_dat"}, 128'(rd_data), 128'(exp_data));
  endtask

  // Pulse swap_req, confirm DRAIN readiness and the completion time of swap_done
  task automatic do_swap(input string tag);
    int n;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    wr_en = 1'b0;
    chk({tag, "_drain_rdrdy"}, 128'(rd_ready), 128'(1'b0));
    chk({tag, "_drain_wrrdy"}, 128'(wr_ready), 128'(1'b1));
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (swap_done) begin
        n = i;
        break;
      end
    end
    chk({tag, "_done_cycles"}, 128'(n), 128'(DRAIN_CYC + 1));
    tick();
    chk({tag, "_done_pulse"}, 128'(swap_done), 128'(1'b0));
  endtask

  initial begin
    logic          rdy [0:3];
    logic [DW-1:0] got [0:1];
    int nv, last_v, sd_k;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_valid", 128'(rd_valid), 128'(1'b0));
    chk("rst_rd_data",  128'(rd_data),  128'(0));
    chk("rst_rd_oob",   128'(rd_oob),   128'(1'b0));
    chk("rst_rd_count", 128'(rd_count), 128'(0));
    chk("rst_wr_count", 128'(wr_count), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(1'b0));
    chk("rst_swap_done",128'(swap_done),128'(1'b0));
    chk("rst_bank_sel", 128'(bank_sel), 128'(1'b0));
    rst_n = 1'b1;
    tick();
    chk("idle_rd_ready", 128'(rd_ready), 128'(1'b1));
    chk("idle_wr_ready", 128'(wr_ready), 128'(1'b1));

    // Read before any swap is out of bounds
    read_chk("oob0", 8'd0, '0, 1'b1);

    // Append three words, swap, read back-to-back
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_data = DW'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    chk("app3_wr_count", 128'(wr_count), 128'(3));
    do_swap("sw1");
    chk("sw1_bank_sel", 128'(bank_sel), 128'(1'b1));
    chk("sw1_rd_count", 128'(rd_count), 128'(3));
    chk("sw1_wr_count", 128'(wr_count), 128'(0));
    for (int k = 0; k < 3 + RD_LAT - 1; k++) begin
      rd_en = (k < 3);
      rd_addr = AW'(k);
      tick();
      if (k >= RD_LAT - 1) begin
        chk("b2b_vld", 128'(rd_valid), 128'(1'b1));
        chk("b2b_dat", 128'(rd_data), 128'(k - (RD_LAT - 1) + 1));
      end
    end
    rd_en = 1'b0;
    tick();
    chk("b2b_idle_vld", 128'(rd_valid), 128'(1'b0));
    chk("b2b_hold_dat", 128'(rd_data), 128'(3));

    // Fill past capacity (write bank is A)
    for (int i = 0; i < PN + 1; i++) begin
      wr_en = 1'b1;
      wr_data = DW'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    chk("full_wr_count", 128'(wr_count), 128'(PN));
    chk("full_overflow", 128'(overflow), 128'(1'b1));
    do_swap("sw2");
    chk("sw2_overflow", 128'(overflow), 128'(1'b0));
    chk("sw2_rd_count", 128'(rd_count), 128'(PN));
    chk("sw2_bank_sel", 128'(bank_sel), 128'(1'b0));
    read_chk("last", 8'd219, DW'(220), 1'b0);
    read_chk("past", 8'd220, '0, 1'b1);

    // Write and swap request in the same IDLE cycle (write bank is B)
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      wr_data = DW'(12'h100 + i);
      tick();
    end
    wr_data = DW'(12'hABC);
    do_swap("sw3");
    chk("sw3_rd_count", 128'(rd_count), 128'(6));
    chk("sw3_bank_sel", 128'(bank_sel), 128'(1'b1));
    read_chk("wsw", 8'd5, DW'(12'hABC), 1'b0);

    // Four consecutive reads with swap_req on the second
    nv = 0;
    last_v = -1;
    sd_k = -1;
    got[0] = '0;
    got[1] = '0;
    for (int k = 0; k < 10; k++) begin
      rd_en = (k < 4);
      rd_addr = AW'(k);
      swap_req = (k == 1);
      if (k < 4) rdy[k] = rd_ready;
      tick();
      if (rd_valid) begin
        if (nv < 2) got[nv] = rd_data;
        nv++;
        last_v = k;
      end
      if (swap_done && sd_k < 0) sd_k = k;
    end
    rd_en = 1'b0;
    swap_req = 1'b0;
    chk("rs_rdy0", 128'(rdy[0]), 128'(1'b1));
    chk("rs_rdy1", 128'(rdy[1]), 128'(1'b1));
    chk("rs_rdy2", 128'(rdy[2]), 128'(1'b0));
    chk("rs_rdy3", 128'(rdy[3]), 128'(1'b0));
    chk("rs_nvalid", 128'(nv), 128'(2));
    chk("rs_dat0", 128'(got[0]), 128'(12'h100));
    chk("rs_dat1", 128'(got[1]), 128'(12'h101));
    chk("rs_swap_after_rd", 128'(sd_k > last_v), 128'(1'b1));
    chk("rs_bank_sel", 128'(bank_sel), 128'(1'b0));

    // Reset asserted while in SWAP
    do_swap("sw5");
    chk("sw5_bank_sel", 128'(bank_sel), 128'(1'b1));
    for (int i = 0; i < 2; i++) begin
      wr_en = 1'b1;
      wr_data = DW'(i + 7);
      tick();
    end
    wr_en = 1'b0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    repeat (DRAIN_CYC) tick();
    chk("inswap_wr_ready", 128'(wr_ready), 128'(1'b0));
    chk("inswap_wr_count", 128'(wr_count), 128'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_bank_sel", 128'(bank_sel), 128'(1'b0));
    chk("mrst_wr_count", 128'(wr_count), 128'(0));
    chk("mrst_rd_count", 128'(rd_count), 128'(0));
    chk("mrst_rd_data",  128'(rd_data),  128'(0));
    chk("mrst_rd_valid", 128'(rd_valid), 128'(1'b0));
    chk("mrst_swap_done",128'(swap_done),128'(1'b0));
    chk("mrst_rd_ready", 128'(rd_ready), 128'(1'b1));
    #2 rst_n = 1'b1;
    tick();
    chk("post_rd_ready", 128'(rd_ready), 128'(1'b1));
    chk("post_wr_ready", 128'(wr_ready), 128'(1'b1));
    chk("post_bank_sel", 128'(bank_sel), 128'(1'b0));
    chk("post_swap_done",128'(swap_done),128'(1'b0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/velocity_cell_pingpong.md
Name: velocity_cell_pingpong

Overview:
Parametrised double-buffered velocity store for one cell, holding particle velocities packed {vz, vy, vx}.
- Read bank: serves current-timestep velocities to the force/motion-update pipeline.
- Write bank: accepts updated velocities, appended in arrival order, from the motion-update unit.
- Bank swap: a handshaked swap at the timestep boundary exchanges the roles of the two banks.
- Particle count: held in registers per bank, not in word 0 of memory.

Parameters:
DATA_WIDTH, 96, packed velocity word width (3 x 32-bit float).
PARTICLE_NUM, 220, words per bank (maximum particles per cell).
ADDR_WIDTH, 8, particle index width; PARTICLE_NUM <= 2**ADDR_WIDTH.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  asynchronous, active-low reset.
rd_en  input  1  read request, accepted when rd_ready=1.
rd_addr  input  ADDR_WIDTH  particle index in read bank.
rd_ready  output  1  read port can accept a request.
rd_valid  output  1  rd_data valid.
rd_data  output  DATA_WIDTH  velocity word.
rd_oob  output  1  accompanies rd_valid when rd_addr >= rd_count.
rd_count  output  ADDR_WIDTH+1  particles in read bank.
wr_en  input  1  append request, accepted when wr_ready=1.
wr_data  input  DATA_WIDTH  velocity to append.
wr_ready  output  1  write port can accept a request.
wr_count  output  ADDR_WIDTH+1  particles in write bank.
overflow  output  1  sticky; an append was dropped because the bank was full.
swap_req  input  1  request bank swap (level, sampled in IDLE).
swap_done  output  1  one-cycle pulse when the swap completes.
bank_sel  output  1  physical bank currently used for reads (0=A, 1=B).

Behaviour:
- Storage: two arrays A and B of PARTICLE_NUM x DATA_WIDTH. Contents are not reset.
- Bank roles: read bank = bank_sel; write bank = ~bank_sel.
- Reset values: rd_data=0, rd_valid=0, rd_oob=0, rd_count=0, wr_count=0, overflow=0, swap_done=0, bank_sel=0, state=IDLE.
- Reset asserted mid-operation aborts any swap or read in flight; counts return to 0.
- Read latency: 1 cycle from an accepted rd_en to rd_valid/rd_data.
  - Back-to-back reads: one per cycle.
  - rd_valid=0 -> rd_data holds its last value.
- Out-of-bounds read (rd_addr >= rd_count): rd_valid=1, rd_oob=1, rd_data=0, no array access.
- Append: an accepted wr_en writes wr_data at write-bank index wr_count, then wr_count increments.
  - If wr_count==PARTICLE_NUM: the write is dropped, wr_count is held and overflow is set.
- FSM states: IDLE, DRAIN, SWAP.
  - IDLE: rd_ready=1, wr_ready=1. swap_req=1 -> DRAIN.
  - DRAIN: rd_ready=0, wr_ready=1. Waits until no read is in flight (rd_valid pipeline empty), then -> SWAP. Takes 1 cycle without the optional feature, 2 with it.
  - SWAP: rd_ready=0, wr_ready=0 for one cycle. Updates: bank_sel<=~bank_sel, rd_count<=wr_count, wr_count<=0, overflow<=0, swap_done<=1. Then -> IDLE.
- Simultaneous events in IDLE:
  - wr_en and swap_req in the same cycle: the write lands in the old write bank and is counted before the swap.
  - rd_en and swap_req in the same cycle: the read is accepted and completes before the swap.
- swap_req held high after swap_done: starts another swap. The requester must deassert it on swap_done.
- Writes never target the read bank, so no read/write address hazard exists.
- Initial load: append all particles, then swap. Reads before the first swap return rd_oob (rd_count=0).

Optional Feature:
VELOCITY_RD_OUT_REG_EN
- Defined: an extra output register stage is added on rd_data/rd_valid/rd_oob, making read latency 2 cycles. Still one read per cycle. DRAIN waits for both stages to empty.
- Undefined: read latency is 1 cycle, as above.

Test Plan:
- Reset then idle: rd_count=0, wr_count=0, bank_sel=0, rd_en at addr 0 -> next cycle rd_valid=1, rd_oob=1, rd_data=0.
- Append 3 words 0x...01/02/03, then pulse swap_req -> swap_done after DRAIN+SWAP, bank_sel=1, rd_count=3, wr_count=0. Reads of addrs 0,1,2 back-to-back -> 01,02,03 on consecutive cycles, at latency 1 (2 with VELOCITY_RD_OUT_REG_EN).
- Append 221 words with PARTICLE_NUM=220 -> wr_count=220, overflow=1, word 221 absent. After swap: overflow=0, rd_count=220, read addr 219 returns word 220.
- wr_en and swap_req in the same IDLE cycle with wr_count=5 -> after swap rd_count=6, and addr 5 holds that word.
- rd_en on 4 consecutive cycles with swap_req asserted on the 2nd: reads 1-2 complete and reads 3-4 are refused (rd_ready=0). The swap occurs only after the last rd_valid.
- Assert rst_n=0 during SWAP -> all outputs return to reset values immediately. After release, the FSM is in IDLE and bank_sel=0.
